// File: rtl/run_monitor_pkg.sv
// Shared encodings for the run controller: FSM states and completion status codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_WFI     = 3'd2,
    ST_ERROR   = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_e;

  // Width of a core index; supports up to 16 cores.
  localparam int unsigned ID_W = 4;

endpackage

// File: rtl/first_set.sv
// Lowest-index priority encoder: reports whether any bit is set and the index of the lowest one.
module first_set
  import run_monitor_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0]    vec_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run controller and end-of-run detector: sequences core reset, counts run cycles and
// latches the cause, core index and address of whatever ends the run.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CORES        = 1,
  parameter int RESET_CYCLES = 5,
  parameter int CNT_WIDTH    = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   all_mode,
  input  logic [CNT_WIDTH-1:0]   timeout_limit,
  input  logic [CORES-1:0]       error,
  input  logic [CORES-1:0]       hlt,
  input  logic [CORES-1:0]       wfi,
  input  logic [CORES*WIDTH-1:0] mem_address,
  output logic                   core_nreset,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [CNT_WIDTH-1:0]   cycles,
  output logic [ID_W-1:0]        core_id,
  output logic [WIDTH-1:0]       last_address
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;
  logic [CORES-1:0]       stopped_q, stopped_d, halted_q, halted_d;
  status_e                status_q, status_d;
  logic [ID_W-1:0]        core_id_q, core_id_d;
  logic [WIDTH-1:0]       last_addr_q, last_addr_d;
  logic                   nreset_q, nreset_d, busy_q, busy_d, done_q, done_d;

  logic                   err_v, hlt_v, wfi_v, new_v;
  logic [ID_W-1:0]        err_idx, hlt_idx, wfi_idx, new_rev_idx, new_last_idx;
  logic [CORES-1:0]       stopped_upd, halted_upd, newly, newly_rev;
  logic [CNT_WIDTH:0]     cyc_plus1;
  logic                   term_v;
  status_e                term_status;
  logic [ID_W-1:0]        term_id;
  logic [WIDTH-1:0]       term_addr;

  // Sticky stop tracking for all-cores mode, including this cycle's flags.
  assign stopped_upd = stopped_q | hlt | wfi;
  assign halted_upd  = halted_q | hlt;
  assign newly       = stopped_upd & ~stopped_q;
  // One extra bit so a saturated counter can never alias a limit.
  assign cyc_plus1   = {1'b0, cycles_q} + (CNT_WIDTH + 1)'(1);

  // The highest newly stopped core is found by encoding the bit-reversed vector.
  for (genvar g = 0; g < CORES; g++) begin : g_rev
    assign newly_rev[g] = newly[CORES - 1 - g];
  end
  assign new_last_idx = ID_W'(CORES - 1) - new_rev_idx;

  first_set #(.N(CORES)) u_err (.vec_i(error),     .valid_o(err_v), .idx_o(err_idx));
  first_set #(.N(CORES)) u_hlt (.vec_i(hlt),       .valid_o(hlt_v), .idx_o(hlt_idx));
  first_set #(.N(CORES)) u_wfi (.vec_i(wfi),       .valid_o(wfi_v), .idx_o(wfi_idx));
  first_set #(.N(CORES)) u_new (.vec_i(newly_rev), .valid_o(new_v), .idx_o(new_rev_idx));

  // Decide whether this cycle's flags end the run, in priority order: error, stop, timeout.
  always_comb begin
    term_v      = 1'b0;
    term_status = ST_NONE;
    term_id     = '0;
    if (err_v) begin
      term_v = 1'b1;  term_status = ST_ERROR;  term_id = err_idx;
    end else if (!all_mode && hlt_v) begin
      term_v = 1'b1;  term_status = ST_HALT;   term_id = hlt_idx;
    end else if (!all_mode && wfi_v) begin
      term_v = 1'b1;  term_status = ST_WFI;    term_id = wfi_idx;
    end else if (all_mode && new_v && (&stopped_upd)) begin
      term_v      = 1'b1;
      term_status = (&halted_upd) ? ST_HALT : ST_WFI;
      term_id     = new_last_idx;
    end else if ((timeout_limit != '0) && (cyc_plus1 == {1'b0, timeout_limit})) begin
      term_v = 1'b1;  term_status = ST_TIMEOUT;  term_id = '0;
    end
  end

  // Select the address slice of the terminating core.
  always_comb begin
    term_addr = mem_address[WIDTH-1:0];
    for (int i = 0; i < CORES; i++) begin
      if (term_id == ID_W'(i)) term_addr = mem_address[i*WIDTH +: WIDTH];
    end
  end

  // FSM next state, counters and result capture.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycles_d    = cycles_q;
    stopped_d   = stopped_q;
    halted_d    = halted_q;
    status_d    = status_q;
    core_id_d   = core_id_q;
    last_addr_d = last_addr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RESET;
          rst_cnt_d   = '0;
          cycles_d    = '0;
          stopped_d   = '0;
          halted_d    = '0;
          status_d    = ST_NONE;
          core_id_d   = '0;
          last_addr_d = '0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == RC_LAST) state_d = S_RUN;
        else                      rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      S_RUN: begin
        cycles_d  = (cycles_q == '1) ? cycles_q : cycles_q + CNT_WIDTH'(1);
        stopped_d = stopped_upd;
        halted_d  = halted_upd;
        if (term_v) begin
          state_d     = S_DONE;
          status_d    = term_status;
          core_id_d   = term_id;
          last_addr_d = term_addr;
        end
      end
      default: state_d = S_IDLE;
    endcase
    nreset_d = (state_d == S_RUN) || (state_d == S_DONE);
    busy_d   = (state_d == S_RESET) || (state_d == S_RUN);
    done_d   = (state_q == S_RUN) && (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cycles_q    <= '0;
      stopped_q   <= '0;
      halted_q    <= '0;
      status_q    <= ST_NONE;
      core_id_q   <= '0;
      last_addr_q <= '0;
      nreset_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      stopped_q   <= stopped_d;
      halted_q    <= halted_d;
      status_q    <= status_d;
      core_id_q   <= core_id_d;
      last_addr_q <= last_addr_d;
      nreset_q    <= nreset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign core_nreset  = nreset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycles       = cycles_q;
  assign core_id      = core_id_q;
  assign last_address = last_addr_q;

endmodule
